// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between the game FSM (master) and the sprite plotter (slave).
interface sprite_plotter_if;
    logic       start;
    logic       item;
    logic       erase;
    logic [2:0] position;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        output start, item, erase, position,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, item, erase, position,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Rasters a press or garbage sprite rectangle, one pixel per clock, onto the vga_adapter bus.
// Optional macro SPRITE_BORDER_EN: paints the sprite perimeter red when not erasing.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; request latched and origin/size computed
// DRAW  | presenting pixel (ox+cx, oy+cy) each clock, row-major
// DONE  | plot low, done pulse, x/y/colour hold
module sprite_plotter #(
    parameter int          LANE_W    = 40,
    parameter int          PRESS_W   = 40,
    parameter int          PRESS_H   = 60,
    parameter int          GARB_W    = 20,
    parameter int          GARB_H    = 20,
    parameter int          GARB_Y    = 100,
    parameter logic [2:0]  PRESS_COL = 3'b111,
    parameter logic [2:0]  GARB_COL  = 3'b010
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    sprite_plotter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t     state;
    logic [2:0] fill_q;
    logic [7:0] ox_q, oy_q, w_q, h_q;
    logic [7:0] cx, cy;
    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       plot_q, busy_q, done_q;
`ifdef SPRITE_BORDER_EN
    logic       erase_q;
`endif

    logic [1:0] req_lane;
    logic       req_valid;
    logic [7:0] req_ox, req_oy, req_w, req_h;
    logic [2:0] req_fill;
    logic [7:0] y_sum;
    logic       row_end, last_px;
    logic [2:0] pix_colour;

    // Press phases 4 and 5 walk back across lanes 2 and 1.
    always_comb begin
        req_lane  = bus.position[1:0];
        req_valid = 1'b0;
        if (bus.item) begin
            req_valid = (bus.position <= 3'd5);
            case (bus.position)
                3'd4:    req_lane = 2'd2;
                3'd5:    req_lane = 2'd1;
                default: req_lane = bus.position[1:0];
            endcase
        end else begin
            req_valid = (bus.position <= 3'd3);
        end
    end

    assign req_ox   = 8'(LANE_W * int'(req_lane)) + (bus.item ? 8'd0 : 8'((LANE_W - GARB_W) / 2));
    assign req_oy   = bus.item ? 8'd0 : 8'(GARB_Y);
    assign req_w    = bus.item ? 8'(PRESS_W) : 8'(GARB_W);
    assign req_h    = bus.item ? 8'(PRESS_H) : 8'(GARB_H);
    assign req_fill = bus.erase ? 3'b000 : (bus.item ? PRESS_COL : GARB_COL);

    assign y_sum   = oy_q + cy;
    assign row_end = (cx == w_q - 8'd1);
    assign last_px = row_end && (cy == h_q - 8'd1);

`ifdef SPRITE_BORDER_EN
    assign pix_colour = (!erase_q && (cx == 8'd0 || row_end || cy == 8'd0 || cy == h_q - 8'd1))
                        ? 3'b100 : fill_q;
`else
    assign pix_colour = fill_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fill_q   <= 3'b000;
            ox_q     <= 8'd0;
            oy_q     <= 8'd0;
            w_q      <= 8'd0;
            h_q      <= 8'd0;
            cx       <= 8'd0;
            cy       <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'b000;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPRITE_BORDER_EN
            erase_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    // done_q still high means the completion cycle: start is dropped there.
                    if (bus.start && !done_q) begin
                        fill_q  <= req_fill;
                        ox_q    <= req_ox;
                        oy_q    <= req_oy;
                        w_q     <= req_w;
                        h_q     <= req_h;
                        cx      <= 8'd0;
                        cy      <= 8'd0;
`ifdef SPRITE_BORDER_EN
                        erase_q <= bus.erase;
`endif
                        state   <= req_valid ? DRAW : DONE;
                    end
                end
                DRAW: begin
                    plot_q   <= 1'b1;
                    busy_q   <= 1'b1;
                    x_q      <= ox_q + cx;
                    y_q      <= y_sum[6:0];
                    colour_q <= pix_colour;
                    if (row_end) begin
                        cx <= 8'd0;
                        cy <= cy + 8'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                    if (last_px) state <= DONE;
                end
                DONE: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b1;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: directed table, hand sequences and random requests vs a geometric model.
module tb_sprite_plotter;

    logic CLOCK_50;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    sprite_plotter_if bus();

    sprite_plotter dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

`ifdef SPRITE_BORDER_EN
    localparam logic [2:0] EDGE_G = 3'b100;
    localparam logic [2:0] EDGE_P = 3'b100;
`else
    localparam logic [2:0] EDGE_G = 3'b010;
    localparam logic [2:0] EDGE_P = 3'b111;
`endif

    typedef struct {
        logic       it;
        logic       er;
        logic [2:0] pos;
        int         npix;
        int         fx, fy, lx, ly;
        logic [2:0] fcol, lcol, icol;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Geometry straight from the screen layout: lanes of 40, press from the top, garbage centred at row 100.
    task automatic model(input logic it, input logic [2:0] pos, output bit valid,
                         output int w, output int h, output int ox, output int oy);
        int press_lane[6] = '{0, 1, 2, 3, 2, 1};
        if (it) begin
            valid = (pos <= 3'd5);
            w = 40; h = 60; oy = 0;
            ox = valid ? 40 * press_lane[pos] : 0;
        end else begin
            valid = (pos <= 3'd3);
            w = 20; h = 20; oy = 100;
            ox = 40 * int'(pos) + 10;
        end
    endtask

    function automatic logic [2:0] exp_col(logic it, logic er, int cx, int cy, int w, int h);
        if (er) return 3'b000;
`ifdef SPRITE_BORDER_EN
        if (cx == 0 || cx == w - 1 || cy == 0 || cy == h - 1) return 3'b100;
`endif
        return it ? 3'b111 : 3'b010;
    endfunction

    task automatic run_req(input string tag, input logic it, input logic er, input logic [2:0] pos,
                           input int restart_at, output int n_plot,
                           output int fx, output int fy, output int lx, output int ly,
                           output logic [2:0] fc, output logic [2:0] lc, output logic [2:0] ic);
        bit valid;
        int w, h, ox, oy, npix, dones, done_t, busy_n, bad, cx, cy;
        model(it, pos, valid, w, h, ox, oy);
        npix = valid ? w * h : 0;
        n_plot = 0; dones = 0; done_t = -1; busy_n = 0; bad = 0;
        fx = -1; fy = -1; lx = -1; ly = -1; fc = 3'b000; lc = 3'b000; ic = 3'b000;
        bus.item = it; bus.erase = er; bus.position = pos; bus.start = 1'b1;
        @(posedge CLOCK_50); #1;
        bus.start = 1'b0;
        check({tag, " accept_cycle_idle"}, {29'd0, bus.busy, bus.plot, bus.done}, 32'd0);
        for (int t = 1; t <= npix + 3; t++) begin
            bus.item = 1'($urandom); bus.erase = 1'($urandom); bus.position = 3'($urandom);
            @(posedge CLOCK_50); #1;
            bus.start = (t == restart_at);
            if (bus.plot) begin
                cx = (w > 0) ? n_plot % w : 0;
                cy = (w > 0) ? n_plot / w : 0;
                if (n_plot == 0) begin fx = int'(bus.x); fy = int'(bus.y); fc = bus.colour; end
                lx = int'(bus.x); ly = int'(bus.y); lc = bus.colour;
                if (n_plot == w + 1) ic = bus.colour;
                if (bus.x !== 8'(ox + cx) || bus.y !== 7'(oy + cy) ||
                    bus.colour !== exp_col(it, er, cx, cy, w, h)) begin
                    if (bad == 0)
                        $display("note %s: pixel %0d at (%0d,%0d) col %0d, model (%0d,%0d) col %0d", tag,
                                 n_plot, bus.x, bus.y, bus.colour, ox + cx, oy + cy, exp_col(it, er, cx, cy, w, h));
                    bad++;
                end
                n_plot++;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin dones++; done_t = t; end
        end
        bus.start = 1'b0;
        check({tag, " pixel_count"}, n_plot, npix);
        check({tag, " bad_pixels"}, bad, 0);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " done_cycle"}, done_t, npix + 1);
        check({tag, " busy_cycles"}, busy_n, npix + 1);
    endtask

    initial begin
        vec_t vecs[6];
        int n, fx, fy, lx, ly;
        logic [2:0] fc, lc, ic;

        vecs[0] = '{it:1'b0, er:1'b0, pos:3'd2, npix:400,  fx:90, fy:100, lx:109, ly:119, fcol:EDGE_G, lcol:EDGE_G, icol:3'b010};
        vecs[1] = '{it:1'b1, er:1'b1, pos:3'd5, npix:2400, fx:40, fy:0,   lx:79,  ly:59,  fcol:3'b000, lcol:3'b000, icol:3'b000};
        vecs[2] = '{it:1'b0, er:1'b0, pos:3'd7, npix:0,    fx:-1, fy:-1,  lx:-1,  ly:-1,  fcol:3'b000, lcol:3'b000, icol:3'b000};
        vecs[3] = '{it:1'b1, er:1'b0, pos:3'd6, npix:0,    fx:-1, fy:-1,  lx:-1,  ly:-1,  fcol:3'b000, lcol:3'b000, icol:3'b000};
        vecs[4] = '{it:1'b1, er:1'b0, pos:3'd4, npix:2400, fx:80, fy:0,   lx:119, ly:59,  fcol:EDGE_P, lcol:EDGE_P, icol:3'b111};
        vecs[5] = '{it:1'b0, er:1'b0, pos:3'd0, npix:400,  fx:10, fy:100, lx:29,  ly:119, fcol:EDGE_G, lcol:EDGE_G, icol:3'b010};

        reset_n = 1'b0;
        bus.start = 1'b0; bus.item = 1'b0; bus.erase = 1'b0; bus.position = 3'd0;
        #25;
        check("reset_xy", {17'd0, bus.x, bus.y}, 32'd0);
        check("reset_ctl", {26'd0, bus.colour, bus.plot, bus.busy, bus.done}, 32'd0);
        @(negedge CLOCK_50); reset_n = 1'b1;
        @(posedge CLOCK_50); #1;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_req(tag, vecs[i].it, vecs[i].er, vecs[i].pos, -1, n, fx, fy, lx, ly, fc, lc, ic);
            check({tag, " table_count"}, n, vecs[i].npix);
            if (vecs[i].npix > 0) begin
                check({tag, " first_xy"}, {fx[15:0], fy[15:0]}, {vecs[i].fx[15:0], vecs[i].fy[15:0]});
                check({tag, " last_xy"}, {lx[15:0], ly[15:0]}, {vecs[i].lx[15:0], vecs[i].ly[15:0]});
                check({tag, " first_col"}, fc, vecs[i].fcol);
                check({tag, " last_col"}, lc, vecs[i].lcol);
                check({tag, " interior_col"}, ic, vecs[i].icol);
            end
        end

        // Start pulses mid-draw and during the done cycle must both be dropped.
        run_req("busy_start", 1'b0, 1'b0, 3'd1, 100, n, fx, fy, lx, ly, fc, lc, ic);
        run_req("done_start", 1'b0, 1'b1, 3'd3, 401, n, fx, fy, lx, ly, fc, lc, ic);
        run_req("inv_done_start", 1'b0, 1'b0, 3'd7, 1, n, fx, fy, lx, ly, fc, lc, ic);

        // Reset 1000 cycles into a press draw.
        bus.item = 1'b1; bus.erase = 1'b0; bus.position = 3'd1; bus.start = 1'b1;
        @(posedge CLOCK_50); #1;
        bus.start = 1'b0;
        repeat (1000) @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_hold_outputs", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        @(posedge CLOCK_50); #5 reset_n = 1'b1;
        @(posedge CLOCK_50); #1;
        check("post_reset_idle", {29'd0, bus.plot, bus.busy, bus.done}, 32'd0);
        run_req("after_reset", 1'b0, 1'b0, 3'd3, -1, n, fx, fy, lx, ly, fc, lc, ic);
        check("after_reset_first_xy", {fx[15:0], fy[15:0]}, {16'd130, 16'd100});

        for (int r = 0; r < 10; r++) begin
            logic       it, er;
            logic [2:0] pos;
            int         ra;
            it  = 1'($urandom);
            er  = 1'($urandom);
            pos = 3'($urandom_range(0, 7));
            ra  = int'($urandom_range(1, 400));
            run_req($sformatf("rand%0d", r), it, er, pos, ra, n, fx, fy, lx, ly, fc, lc, ic);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
